// File: rtl/bus_pkg.sv
// Shared state encoding and address-map constants for the data-memory bus demux.
package bus_pkg;

    localparam int unsigned TGT_COUNT = 4;
    localparam int unsigned TGT_SEL_W = 2;

    localparam logic [TGT_SEL_W-1:0] TGT_RAM   = 2'd0;
    localparam logic [TGT_SEL_W-1:0] TGT_ROM   = 2'd1;
    localparam logic [TGT_SEL_W-1:0] TGT_GPIO  = 2'd2;
    localparam logic [TGT_SEL_W-1:0] TGT_TIMER = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Address decoder: picks the target from two address bits and flags any set bit above them.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SEL_LSB    = 28
) (
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [TGT_SEL_W-1:0]  sel,
    output logic                  dec_err
);

    // Shifting past the top of the address yields zero, so a map that fills the
    // whole address space never reports a decode error.
    assign sel     = TGT_SEL_W'(req_addr >> SEL_LSB);
    assign dec_err = (req_addr >> (SEL_LSB + TGT_SEL_W)) != '0;

endmodule

// File: rtl/bus_demux_4.sv
// Routes one load/store request port to four targets with a single outstanding
// transaction, returning a registered response, decode errors and timeouts.
module bus_demux_4
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_LSB        = 28,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic                            req_we,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    input  logic [DATA_WIDTH/8-1:0]         req_be,
    output logic                            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [TGT_COUNT-1:0]            t_req_valid,
    input  logic [TGT_COUNT-1:0]            t_req_ready,
    output logic [ADDR_WIDTH-1:0]           t_addr,
    output logic                            t_we,
    output logic [DATA_WIDTH-1:0]           t_wdata,
    output logic [DATA_WIDTH/8-1:0]         t_be,
    input  logic [TGT_COUNT-1:0]            t_rsp_valid,
    input  logic [TGT_COUNT*DATA_WIDTH-1:0] t_rsp_rdata
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t               state_q, state_d;
    logic [TGT_SEL_W-1:0] pending_q, pending_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                 rsp_err_d;

    logic [TGT_SEL_W-1:0] sel;
    logic                 dec_err;
    logic                 timeout_hit;
    logic [DATA_WIDTH-1:0] tgt_rdata [TGT_COUNT];

    bus_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SEL_LSB    (SEL_LSB)
    ) u_decode (
        .req_addr (req_addr),
        .sel      (sel),
        .dec_err  (dec_err)
    );

    for (genvar i = 0; i < TGT_COUNT; i++) begin : g_unpack
        assign tgt_rdata[i] = t_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Request payload is broadcast; only t_req_valid steers it.
    assign t_addr  = req_addr;
    assign t_we    = req_we;
    assign t_wdata = req_wdata;
    assign t_be    = req_be;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            timer_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        timer_d     = timer_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        req_ready   = 1'b0;
        t_req_valid = '0;

        case (state_q)
            IDLE: begin
                // Undecodable requests are swallowed at once and answered from ERR.
                req_ready = dec_err | t_req_ready[sel];
                if (!dec_err) begin
                    t_req_valid[sel] = req_valid;
                end
                if (req_valid && req_ready) begin
                    if (dec_err) begin
                        state_d = ERR;
                    end else begin
                        pending_d = sel;
                        timer_d   = '0;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                // A response beats a timeout landing in the same cycle.
                if (t_rsp_valid[pending_q]) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = tgt_rdata[pending_q];
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ERR: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_demux_4.sv
// Bench for bus_demux_4: directed address-map scenarios, then randomized traffic
// checked every cycle against a transaction-level model.
module tb_bus_demux_4;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int NT = 4;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              req_we;
    logic [DW-1:0]     req_wdata;
    logic [BW-1:0]     req_be;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NT-1:0]     t_req_valid;
    logic [NT-1:0]     t_req_ready;
    logic [AW-1:0]     t_addr;
    logic              t_we;
    logic [DW-1:0]     t_wdata;
    logic [BW-1:0]     t_be;
    logic [NT-1:0]     t_rsp_valid;
    logic [NT*DW-1:0]  t_rsp_rdata;

    always #5 clk = ~clk;

    bus_demux_4 #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .SEL_LSB        (28),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .t_req_valid (t_req_valid),
        .t_req_ready (t_req_ready),
        .t_addr      (t_addr),
        .t_we        (t_we),
        .t_wdata     (t_wdata),
        .t_be        (t_be),
        .t_rsp_valid (t_rsp_valid),
        .t_rsp_rdata (t_rsp_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding request, its age, and the response due next.
    bit            armed = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_dec = 1'b0;
    int            m_tgt = 0;
    int            m_wait = 0;
    bit            m_pulse = 1'b0;
    bit            m_perr = 1'b0;
    logic [DW-1:0] m_pdata = '0;
    logic [DW-1:0] m_last_data = '0;
    bit            m_last_err = 1'b0;

    always @(negedge clk) begin
        int            sel;
        bit            dec;
        bit            ready_exp;
        logic [NT-1:0] tv_exp;
        if (armed) begin
            sel = int'((req_addr >> 28) % 4);
            dec = (req_addr >> 30) != 0;

            if (m_pulse) begin
                check("rsp_valid", rsp_valid, 1'b1);
                check("rsp_err", rsp_err, m_perr);
                check("rsp_rdata", rsp_rdata, m_pdata);
                m_last_data = m_pdata;
                m_last_err  = m_perr;
            end else begin
                check("rsp_valid_idle", rsp_valid, 1'b0);
                check("rsp_rdata_hold", rsp_rdata, m_last_data);
                check("rsp_err_hold", rsp_err, m_last_err);
            end

            check("t_addr", t_addr, req_addr);
            check("t_we", t_we, req_we);
            check("t_wdata", t_wdata, req_wdata);
            check("t_be", t_be, req_be);

            tv_exp = '0;
            if (m_busy) begin
                ready_exp = 1'b0;
            end else begin
                ready_exp = dec || t_req_ready[sel];
                if (req_valid && !dec) tv_exp[sel] = 1'b1;
            end
            check("req_ready", req_ready, ready_exp);
            check("t_req_valid", t_req_valid, tv_exp);

            m_pulse = 1'b0;
            if (rst) begin
                m_busy      = 1'b0;
                m_last_data = '0;
                m_last_err  = 1'b0;
            end else if (!m_busy) begin
                if (req_valid && ready_exp) begin
                    m_busy = 1'b1;
                    m_dec  = dec;
                    m_tgt  = sel;
                    m_wait = 0;
                end
            end else if (m_dec) begin
                m_busy = 1'b0; m_pulse = 1'b1; m_perr = 1'b1; m_pdata = '0;
            end else if (t_rsp_valid[m_tgt]) begin
                m_busy = 1'b0; m_pulse = 1'b1; m_perr = 1'b0;
                m_pdata = t_rsp_rdata[m_tgt*DW +: DW];
            end else if (m_wait == TO - 1) begin
                m_busy = 1'b0; m_pulse = 1'b1; m_perr = 1'b1; m_pdata = '0;
            end else begin
                m_wait++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    int            cnt [NT];
    logic [NT-1:0] owned;
    logic [NT-1:0] tacc;
    bit            acc;
    int            s;
    int            hi;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
        req_be = '0; t_req_ready = '0; t_rsp_valid = '0; t_rsp_rdata = '0;
        nxt();
        armed = 1'b1;
        smp();
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", rsp_err, 1'b0);
        nxt();
        rst = 1'b0;

        // Read from ROM, response three cycles after acceptance
        nxt(); req_valid = 1'b1; req_addr = 32'h1000_0010; req_we = 1'b0; req_be = 4'hF; t_req_ready = 4'b0010;
        smp(); check("rd_t_req_valid", t_req_valid, 4'b0010); check("rd_req_ready", req_ready, 1'b1);
        nxt(); req_valid = 1'b0; t_req_ready = 4'b0000;
        smp(); check("rd_t_req_valid_once", t_req_valid, 4'b0000);
        nxt();
        nxt(); t_rsp_valid = 4'b0010; t_rsp_rdata[63:32] = 32'hDEAD_BEEF;
        smp(); check("rd_rsp_not_early", rsp_valid, 1'b0);
        nxt(); t_rsp_valid = 4'b0000;
        smp(); check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF); check("rd_rsp_err", rsp_err, 1'b0);

        // Write to GPIO stalled two cycles by target ready
        nxt(); req_valid = 1'b1; req_addr = 32'h2000_0004; req_we = 1'b1; req_wdata = 32'h1234_5678;
        req_be = 4'b0011; t_req_ready = 4'b1011;
        smp(); check("wr_stall0", req_ready, 1'b0); check("wr_t_be", t_be, 4'b0011);
        check("wr_t_req_valid", t_req_valid, 4'b0100);
        nxt();
        smp(); check("wr_stall1", req_ready, 1'b0);
        nxt(); t_req_ready = 4'b0100;
        smp(); check("wr_accept", req_ready, 1'b1);
        nxt(); req_valid = 1'b0; req_we = 1'b0; t_rsp_valid = 4'b0100; t_rsp_rdata = '0;
        smp(); check("wr_rsp_not_early", rsp_valid, 1'b0);
        nxt(); t_rsp_valid = 4'b0000;
        smp(); check("wr_rsp_valid", rsp_valid, 1'b1); check("wr_rsp_err", rsp_err, 1'b0);

        // Undecodable address
        nxt(); req_valid = 1'b1; req_addr = 32'h4000_0000; t_req_ready = 4'b0000;
        smp(); check("dec_ready", req_ready, 1'b1); check("dec_no_t_req_valid", t_req_valid, 4'b0000);
        nxt(); req_valid = 1'b0;
        smp(); check("dec_err_cycle_ready", req_ready, 1'b0);
        nxt();
        smp(); check("dec_rsp_valid", rsp_valid, 1'b1); check("dec_rsp_err", rsp_err, 1'b1);
        check("dec_rsp_rdata", rsp_rdata, 32'h0);

        // Timer target never answers
        nxt(); req_valid = 1'b1; req_addr = 32'h3000_0000; t_req_ready = 4'b1000;
        smp(); check("to_accept", req_ready, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            nxt(); req_valid = 1'b0;
            smp(); check("to_no_early_rsp", rsp_valid, 1'b0);
        end
        nxt();
        smp(); check("to_rsp_valid", rsp_valid, 1'b1); check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_rdata", rsp_rdata, 32'h0);
        nxt(); t_rsp_valid = 4'b1000; t_rsp_rdata[127:96] = 32'hCAFE_0003;
        nxt(); t_rsp_valid = 4'b0000;
        smp(); check("to_late_ignored", rsp_valid, 1'b0); check("to_late_err_held", rsp_err, 1'b1);

        // RAM read with a spurious GPIO pulse, plus a back-to-back ROM request
        nxt(); req_valid = 1'b1; req_addr = 32'h0000_0100; t_req_ready = 4'b1111;
        nxt(); req_addr = 32'h1000_0000; t_rsp_valid = 4'b0100; t_rsp_rdata[95:64] = 32'h0BAD_0BAD;
        smp(); check("b2b_blocked", req_ready, 1'b0);
        nxt(); t_rsp_valid = 4'b0101; t_rsp_rdata[31:0] = 32'h600D_F00D;
        smp(); check("spur_ignored", rsp_valid, 1'b0);
        nxt(); t_rsp_valid = 4'b0000;
        smp(); check("spur_rsp_valid", rsp_valid, 1'b1); check("spur_rsp_rdata", rsp_rdata, 32'h600D_F00D);
        check("b2b_ready", req_ready, 1'b1); check("b2b_t_req_valid", t_req_valid, 4'b0010);
        nxt(); req_valid = 1'b0; t_rsp_valid = 4'b0010; t_rsp_rdata[63:32] = 32'h1111_2222;
        nxt(); t_rsp_valid = 4'b0000;
        smp(); check("b2b_rsp_rdata", rsp_rdata, 32'h1111_2222);

        // Reset while waiting, then a late target pulse
        nxt(); req_valid = 1'b1; req_addr = 32'h1000_0020; t_req_ready = 4'b0010;
        nxt(); req_valid = 1'b0; rst = 1'b1;
        nxt(); rst = 1'b0; t_rsp_valid = 4'b0010; t_rsp_rdata[63:32] = 32'h5555_5555;
        smp(); check("rst_rsp_valid", rsp_valid, 1'b0); check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        nxt(); t_rsp_valid = 4'b0000;
        smp(); check("rst_late_ignored", rsp_valid, 1'b0);
        nxt(); req_valid = 1'b1; req_addr = 32'h0000_0040; t_req_ready = 4'b0001;
        smp(); check("post_rst_accept", req_ready, 1'b1);
        nxt(); req_valid = 1'b0; t_rsp_valid = 4'b0001; t_rsp_rdata[31:0] = 32'h7777_0001;
        nxt(); t_rsp_valid = 4'b0000;
        smp(); check("post_rst_rdata", rsp_rdata, 32'h7777_0001);

        // Randomized traffic: targets answer within the timeout or stay silent
        for (int t = 0; t < NT; t++) cnt[t] = -1;
        owned = '0;
        for (int i = 0; i < 3000; i++) begin
            smp();
            acc  = req_valid && req_ready;
            tacc = t_req_valid & t_req_ready;
            if (rsp_valid) owned = '0;
            owned = owned | tacc;
            for (int t = 0; t < NT; t++) begin
                if (tacc[t]) cnt[t] = ($urandom_range(0, 7) == 0) ? -2 : int'($urandom_range(0, 3));
            end
            nxt();
            if (!req_valid || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    s  = int'($urandom_range(0, 3));
                    hi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
                    req_valid = 1'b1;
                    req_addr  = (32'(hi) << 30) | (32'(s) << 28) | ($urandom & 32'h0FFF_FFFF);
                    req_we    = 1'($urandom);
                    req_wdata = $urandom;
                    req_be    = 4'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end
            t_req_ready = 4'($urandom);
            t_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
            t_rsp_valid = '0;
            for (int t = 0; t < NT; t++) begin
                if (cnt[t] == 0) begin
                    t_rsp_valid[t] = 1'b1;
                    cnt[t] = -1;
                end else if (cnt[t] > 0) begin
                    cnt[t]--;
                end else if (cnt[t] == -1 && !owned[t] && $urandom_range(0, 15) == 0) begin
                    t_rsp_valid[t] = 1'b1;
                end
            end
        end
        smp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
